// File: rtl/hci_package.sv
// rtl/hci_package.sv - shared types for the HCI core arbiter
package hci_package;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } hci_arb_state_e;

endpackage

// File: rtl/hci_core_arbiter_route_fifo.sv
// rtl/hci_core_arbiter_route_fifo.sv - winner-index FIFO routing in-order responses
module hci_core_arbiter_route_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap explicitly so non-power-of-2 depths stay in range
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hci_core_arbiter_ooo_guard.sv
// rtl/hci_core_arbiter_ooo_guard.sv - round-robin HCI arbiter with request lock; optional HCI_CORE_ARB_PRIO_EN
module hci_core_arbiter_ooo_guard
    import hci_package::*;
#(
    parameter int unsigned NB_IN_CHAN      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned DW              = 32,
    parameter int unsigned AW              = 32,
    parameter int unsigned BW              = DW / 8,
    parameter int unsigned UW              = 4,
    parameter int unsigned IW              = 4,
    parameter int unsigned EW              = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
`ifdef HCI_CORE_ARB_PRIO_EN
    input  logic [NB_IN_CHAN-1:0]          prio_i,
`endif
    input  logic [NB_IN_CHAN-1:0]          in_req,
    output logic [NB_IN_CHAN-1:0]          in_gnt,
    input  logic [NB_IN_CHAN-1:0][AW-1:0]  in_add,
    input  logic [NB_IN_CHAN-1:0]          in_wen,
    input  logic [NB_IN_CHAN-1:0][BW-1:0]  in_be,
    input  logic [NB_IN_CHAN-1:0][DW-1:0]  in_data,
    input  logic [NB_IN_CHAN-1:0][UW-1:0]  in_user,
    input  logic [NB_IN_CHAN-1:0][IW-1:0]  in_id,
    input  logic [NB_IN_CHAN-1:0][EW-1:0]  in_ecc,
    output logic [NB_IN_CHAN-1:0][DW-1:0]  in_r_data,
    output logic [NB_IN_CHAN-1:0]          in_r_valid,
    input  logic [NB_IN_CHAN-1:0]          in_r_ready,
    output logic [NB_IN_CHAN-1:0][UW-1:0]  in_r_user,
    output logic [NB_IN_CHAN-1:0][IW-1:0]  in_r_id,
    output logic [NB_IN_CHAN-1:0][EW-1:0]  in_r_ecc,
    output logic                           out_req,
    input  logic                           out_gnt,
    output logic [AW-1:0]                  out_add,
    output logic                           out_wen,
    output logic [BW-1:0]                  out_be,
    output logic [DW-1:0]                  out_data,
    output logic [UW-1:0]                  out_user,
    output logic [IW-1:0]                  out_id,
    output logic [EW-1:0]                  out_ecc,
    input  logic [DW-1:0]                  out_r_data,
    input  logic                           out_r_valid,
    output logic                           out_r_ready,
    input  logic [UW-1:0]                  out_r_user,
    input  logic [IW-1:0]                  out_r_id,
    input  logic [EW-1:0]                  out_r_ecc,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int unsigned SW = $clog2(NB_IN_CHAN);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    hci_arb_state_e        state;
    logic [SW-1:0]         rr_ptr;
    logic [SW-1:0]         win_q;
    logic [SW-1:0]         winner;
    logic [SW-1:0]         sel;
    logic [SW-1:0]         head;
    logic [NB_IN_CHAN-1:0] eligible;
    logic                  found;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  grant;
    logic                  pop;

`ifdef HCI_CORE_ARB_PRIO_EN
    // A pending priority request restricts arbitration to the priority class
    assign eligible = (|(in_req & prio_i)) ? (in_req & prio_i) : in_req;
`else
    assign eligible = in_req;
`endif

    // Two passes: first from rr_ptr upward, then wrap to the bottom
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < int'(NB_IN_CHAN); k++) begin
            if (!found && eligible[k] && (SW'(k) >= rr_ptr)) begin
                winner = SW'(k);
                found  = 1'b1;
            end
        end
        for (int k = 0; k < int'(NB_IN_CHAN); k++) begin
            if (!found && eligible[k]) begin
                winner = SW'(k);
                found  = 1'b1;
            end
        end
    end

    assign sel     = (state == LOCKED) ? win_q : winner;
    assign out_req = !full && ((state == LOCKED) ? in_req[sel] : (|eligible));
    assign grant   = out_req && out_gnt;

    always_comb begin
        in_gnt      = '0;
        in_gnt[sel] = grant;
    end

    assign out_add  = in_add[sel];
    assign out_wen  = in_wen[sel];
    assign out_be   = in_be[sel];
    assign out_data = in_data[sel];
    assign out_user = in_user[sel];
    assign out_id   = in_id[sel];
    assign out_ecc  = in_ecc[sel];

    assign out_r_ready = empty ? 1'b1 : in_r_ready[head];
    assign pop         = out_r_valid && out_r_ready && !empty;

    always_comb begin
        in_r_valid = '0;
        if (!empty) in_r_valid[head] = out_r_valid;
    end

    assign in_r_data = {NB_IN_CHAN{out_r_data}};
    assign in_r_user = {NB_IN_CHAN{out_r_user}};
    assign in_r_id   = {NB_IN_CHAN{out_r_id}};
    assign in_r_ecc  = {NB_IN_CHAN{out_r_ecc}};

    assign busy_o = (count != '0) || (state == LOCKED);

    hci_core_arbiter_route_fifo #(
        .WIDTH (SW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .push      (grant),
        .push_data (sel),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Leaving LOCKED needs a real grant, so a full FIFO keeps win_q pinned
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ARB;
            win_q  <= '0;
            rr_ptr <= '0;
            err_o  <= 1'b0;
        end else if (clear_i) begin
            state  <= ARB;
            win_q  <= '0;
            rr_ptr <= '0;
            err_o  <= 1'b0;
        end else begin
            if (grant) begin
                rr_ptr <= (sel == SW'(NB_IN_CHAN - 1)) ? '0 : sel + 1'b1;
            end
            if (out_r_valid && empty) begin
                err_o <= 1'b1;
            end
            case (state)
                ARB: begin
                    if (out_req && !out_gnt) begin
                        state <= LOCKED;
                        win_q <= winner;
                    end
                end
                LOCKED: begin
                    if (grant) state <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_hci_core_arbiter_ooo_guard.sv
// tb/tb_hci_core_arbiter_ooo_guard.sv - directed self-checking bench for the HCI arbiter
`timescale 1ns/1ps
module tb_hci_core_arbiter_ooo_guard;

    localparam int N = 4, MO = 2, DW = 32, AW = 32, BW = 4, UW = 4, IW = 4, EW = 1;

    logic clk = 1'b0;
    logic rst, clear;
`ifdef HCI_CORE_ARB_PRIO_EN
    logic [N-1:0] prio;
`endif
    logic [N-1:0]          in_req, in_gnt, in_wen, in_r_valid, in_r_ready;
    logic [N-1:0][AW-1:0]  in_add;
    logic [N-1:0][BW-1:0]  in_be;
    logic [N-1:0][DW-1:0]  in_data, in_r_data;
    logic [N-1:0][UW-1:0]  in_user, in_r_user;
    logic [N-1:0][IW-1:0]  in_id, in_r_id;
    logic [N-1:0][EW-1:0]  in_ecc, in_r_ecc;
    logic                  out_req, out_gnt, out_wen, out_r_valid, out_r_ready;
    logic [AW-1:0]         out_add;
    logic [BW-1:0]         out_be;
    logic [DW-1:0]         out_data, out_r_data;
    logic [UW-1:0]         out_user, out_r_user;
    logic [IW-1:0]         out_id, out_r_id;
    logic [EW-1:0]         out_ecc, out_r_ecc;
    logic                  busy, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hci_core_arbiter_ooo_guard #(
        .NB_IN_CHAN(N), .MAX_OUTSTANDING(MO), .DW(DW), .AW(AW), .BW(BW), .UW(UW), .IW(IW), .EW(EW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
`ifdef HCI_CORE_ARB_PRIO_EN
        .prio_i(prio),
`endif
        .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen), .in_be(in_be),
        .in_data(in_data), .in_user(in_user), .in_id(in_id), .in_ecc(in_ecc),
        .in_r_data(in_r_data), .in_r_valid(in_r_valid), .in_r_ready(in_r_ready),
        .in_r_user(in_r_user), .in_r_id(in_r_id), .in_r_ecc(in_r_ecc),
        .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen), .out_be(out_be),
        .out_data(out_data), .out_user(out_user), .out_id(out_id), .out_ecc(out_ecc),
        .out_r_data(out_r_data), .out_r_valid(out_r_valid), .out_r_ready(out_r_ready),
        .out_r_user(out_r_user), .out_r_id(out_r_id), .out_r_ecc(out_r_ecc),
        .busy_o(busy), .err_o(err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_req      = '0;
        out_gnt     = 1'b0;
        out_r_valid = 1'b0;
        out_r_data  = '0;
        in_r_ready  = '1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL rst_out_req: got %b expected 0", out_req); end
        checks++; if (out_r_ready !== 1'b1) begin errors++; $display("FAIL rst_r_ready: got %b expected 1", out_r_ready); end
        checks++; if (in_gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b expected 0000", in_gnt); end
        checks++; if (in_r_valid !== 4'b0000) begin errors++; $display("FAIL rst_r_valid: got %b expected 0000", in_r_valid); end
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_busy_err: got %b%b expected 00", busy, err); end
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_round_robin;
        int exp_w[6] = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 7; i++) begin
            in_req      = (i < 6) ? 4'b0111 : 4'b0000;
            out_gnt     = 1'b1;
            out_r_valid = (i > 0);
            out_r_data  = 32'(32'hD0 + i);
            @(negedge clk);
            if (i < 6) begin
                checks++; if (in_gnt !== 4'(1 << exp_w[i])) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, in_gnt, 4'(1 << exp_w[i])); end
                checks++; if (out_add !== 32'(32'hA0 + exp_w[i])) begin errors++; $display("FAIL rr_add[%0d]: got %h expected %h", i, out_add, 32'(32'hA0 + exp_w[i])); end
            end
            if (i > 0) begin
                checks++; if (in_r_valid !== 4'(1 << exp_w[i-1])) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, in_r_valid, 4'(1 << exp_w[i-1])); end
                checks++; if (in_r_data[exp_w[i-1]] !== 32'(32'hD0 + i)) begin errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", i, in_r_data[exp_w[i-1]], 32'(32'hD0 + i)); end
            end
            tick;
        end
        idle;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_end: got %b expected 0", busy); end
        tick;
    endtask

    // rr_ptr is 3 on entry
    task automatic test_lock;
        in_req = 4'b0010; out_gnt = 1'b0;
        @(negedge clk);
        checks++; if (out_req !== 1'b1 || out_add !== 32'hA1 || in_gnt !== 4'b0000) begin errors++; $display("FAIL lock_c0: got req=%b add=%h gnt=%b expected 1 a1 0000", out_req, out_add, in_gnt); end
        tick;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy: got %b expected 1", busy); end
        checks++; if (out_data !== 32'h5001 || out_id !== 4'd1) begin errors++; $display("FAIL lock_payload: got %h/%h expected 5001/1", out_data, out_id); end
        tick;
        in_req = 4'b0011;
        @(negedge clk);
        checks++; if (out_add !== 32'hA1 || in_gnt !== 4'b0000) begin errors++; $display("FAIL lock_hold: got add=%h gnt=%b expected a1 0000", out_add, in_gnt); end
        tick;
        out_gnt = 1'b1;
        @(negedge clk);
        checks++; if (in_gnt !== 4'b0010 || out_add !== 32'hA1) begin errors++; $display("FAIL lock_grant: got gnt=%b add=%h expected 0010 a1", in_gnt, out_add); end
        tick;
        in_req = 4'b0001;
        @(negedge clk);
        checks++; if (in_gnt !== 4'b0001 || out_add !== 32'hA0) begin errors++; $display("FAIL lock_next: got gnt=%b add=%h expected 0001 a0", in_gnt, out_add); end
        tick;
        in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b1; out_r_data = 32'hE1;
        @(negedge clk);
        checks++; if (in_r_valid !== 4'b0010 || in_r_data[1] !== 32'hE1) begin errors++; $display("FAIL lock_resp1: got %b/%h expected 0010/e1", in_r_valid, in_r_data[1]); end
        tick;
        out_r_data = 32'hE0;
        @(negedge clk);
        checks++; if (in_r_valid !== 4'b0001) begin errors++; $display("FAIL lock_resp0: got %b expected 0001", in_r_valid); end
        tick;
        idle;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_busy_end: got %b expected 0", busy); end
        tick;
    endtask

    // rr_ptr is 1 on entry
    task automatic test_fifo_full;
        in_req = 4'b0100; out_gnt = 1'b1;
        @(negedge clk);
        checks++; if (in_gnt !== 4'b0100) begin errors++; $display("FAIL full_g0: got %b expected 0100", in_gnt); end
        tick;
        in_req = 4'b1000;
        @(negedge clk);
        checks++; if (in_gnt !== 4'b1000) begin errors++; $display("FAIL full_g1: got %b expected 1000", in_gnt); end
        tick;
        in_req = 4'b0001;
        @(negedge clk);
        checks++; if (out_req !== 1'b0 || in_gnt !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL full_block: got req=%b gnt=%b busy=%b expected 0 0000 1", out_req, in_gnt, busy); end
        tick;
        out_r_valid = 1'b1;
        @(negedge clk);
        checks++; if (out_req !== 1'b0 || in_gnt !== 4'b0000) begin errors++; $display("FAIL full_pop_same: got req=%b gnt=%b expected 0 0000", out_req, in_gnt); end
        checks++; if (in_r_valid !== 4'b0100) begin errors++; $display("FAIL full_resp2: got %b expected 0100", in_r_valid); end
        tick;
        out_r_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_req !== 1'b1 || in_gnt !== 4'b0001) begin errors++; $display("FAIL full_resume: got req=%b gnt=%b expected 1 0001", out_req, in_gnt); end
        tick;
        in_req = '0; out_r_valid = 1'b1;
        @(negedge clk);
        checks++; if (in_r_valid !== 4'b1000) begin errors++; $display("FAIL full_resp3: got %b expected 1000", in_r_valid); end
        tick;
        @(negedge clk);
        checks++; if (in_r_valid !== 4'b0001) begin errors++; $display("FAIL full_resp0: got %b expected 0001", in_r_valid); end
        tick;
        idle;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b expected 0", busy); end
        tick;
    endtask

    task automatic test_backpressure;
        in_req = 4'b0010; out_gnt = 1'b1;
        @(negedge clk);
        checks++; if (in_gnt !== 4'b0010) begin errors++; $display("FAIL bp_gnt: got %b expected 0010", in_gnt); end
        tick;
        in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b1; out_r_data = 32'hBEEF; in_r_ready = 4'b1101;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (out_r_ready !== 1'b0 || in_r_valid !== 4'b0010) begin errors++; $display("FAIL bp_stall[%0d]: got rdy=%b rv=%b expected 0 0010", c, out_r_ready, in_r_valid); end
            checks++; if (in_r_data[1] !== 32'hBEEF || busy !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got %h busy=%b expected beef 1", c, in_r_data[1], busy); end
            tick;
        end
        in_r_ready = 4'b1111;
        @(negedge clk);
        checks++; if (out_r_ready !== 1'b1 || in_r_valid !== 4'b0010) begin errors++; $display("FAIL bp_accept: got rdy=%b rv=%b expected 1 0010", out_r_ready, in_r_valid); end
        tick;
        idle;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || err !== 1'b0 || in_r_valid !== 4'b0000) begin errors++; $display("FAIL bp_end: got busy=%b err=%b rv=%b expected 0 0 0000", busy, err, in_r_valid); end
        tick;
    endtask

    task automatic test_err_sticky;
        out_r_valid = 1'b1;
        @(negedge clk);
        checks++; if (in_r_valid !== 4'b0000 || out_r_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL err_pulse: got rv=%b rdy=%b err=%b expected 0000 1 0", in_r_valid, out_r_ready, err); end
        tick;
        idle;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky[%0d]: got %b expected 1", c, err); end
            tick;
        end
        clear = 1'b1;
        tick;
        clear = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
        tick;
    endtask

`ifdef HCI_CORE_ARB_PRIO_EN
    task automatic test_prio;
        logic [3:0] exp_g[4] = '{4'b0100, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] exp_v[5] = '{4'b0000, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            prio        = (i < 2) ? 4'b0100 : 4'b0000;
            in_req      = (i < 4) ? 4'b1111 : 4'b0000;
            out_gnt     = 1'b1;
            out_r_valid = (i > 0);
            @(negedge clk);
            if (i < 4) begin
                checks++; if (in_gnt !== exp_g[i]) begin errors++; $display("FAIL prio_gnt[%0d]: got %b expected %b", i, in_gnt, exp_g[i]); end
            end
            checks++; if (in_r_valid !== exp_v[i]) begin errors++; $display("FAIL prio_rv[%0d]: got %b expected %b", i, in_r_valid, exp_v[i]); end
            tick;
        end
        prio = '0;
        idle;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_busy_end: got %b expected 0", busy); end
        tick;
    endtask
`endif

    task automatic test_async_reset;
        in_req = 4'b0001; out_gnt = 1'b1;
        tick;
        in_req = 4'b0010; out_gnt = 1'b0;
        @(negedge clk);
        checks++; if (out_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ar_pre: got req=%b busy=%b expected 1 1", out_req, busy); end
        tick;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || out_r_ready !== 1'b1 || in_gnt !== 4'b0000) begin errors++; $display("FAIL ar_now: got busy=%b rdy=%b gnt=%b expected 0 1 0000", busy, out_r_ready, in_gnt); end
        idle;
        tick;
        rst = 1'b0;
        tick;
    endtask

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
`ifdef HCI_CORE_ARB_PRIO_EN
        prio  = '0;
`endif
        idle;
        for (int k = 0; k < N; k++) begin
            in_add[k]  = 32'(32'hA0 + k);
            in_data[k] = 32'(32'h5000 + k);
            in_be[k]   = 4'(k);
            in_wen[k]  = 1'(k & 1);
            in_user[k] = 4'(k);
            in_id[k]   = 4'(k);
            in_ecc[k]  = 1'(k & 1);
        end
        out_r_user = '0;
        out_r_id   = '0;
        out_r_ecc  = '0;

        test_reset;
        test_round_robin;
        test_lock;
        test_fifo_full;
        test_backpressure;
        test_err_sticky;
`ifdef HCI_CORE_ARB_PRIO_EN
        test_prio;
`endif
        test_async_reset;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
